// File: rtl/icache_dm_if.sv
// Fetch-side and instruction-memory-side signals of the direct-mapped I-cache.
// slave is the cache's view; master is the datapath/memory-controller view.
interface icache_dm_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-line instruction cache with a blocking fill.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_dm #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  icache_dm_if.slave  cif
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, next_state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [31:0]       data [SETS];
  logic [31:0]       miss_addr;

  logic [IDX_W-1:0]  addr_idx, miss_idx;
  logic [TAG_W-1:0]  addr_tag, miss_tag;
  logic              tag_match;
  logic              latch_miss, fill_done;
  logic              unused_offset;

  assign addr_idx      = cif.imemaddr[IDX_W+1:2];
  assign addr_tag      = cif.imemaddr[31:IDX_W+2];
  assign miss_idx      = miss_addr[IDX_W+1:2];
  assign miss_tag      = miss_addr[31:IDX_W+2];
  assign tag_match     = valid[addr_idx] && (tags[addr_idx] == addr_tag);
  assign unused_offset = ^cif.imemaddr[1:0];

  // Outputs are held at zero while RST is high so nothing leaks during reset.
  always_comb begin
    next_state   = state;
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    latch_miss   = 1'b0;
    fill_done    = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (cif.imemREN && !cif.flush) begin
            if (tag_match) begin
              cif.ihit     = 1'b1;
              cif.imemload = data[addr_idx];
            end else begin
              latch_miss = 1'b1;
              next_state = FILL;
            end
          end
        end
        FILL: begin
          cif.iREN  = 1'b1;
          cif.iaddr = miss_addr;
          if (cif.flush) begin
            next_state = IDLE;
          end else if (!cif.iwait) begin
            fill_done  = 1'b1;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (latch_miss)
        miss_addr <= {cif.imemaddr[31:2], 2'b00};
      if (cif.flush)
        valid <= '0;
      else if (fill_done)
        valid[miss_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; valid alone qualifies it.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= cif.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (cif.ihit && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (latch_miss && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm (SETS=16); honours ICACHE_STATS_EN.
module tb_icache_dm;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hits = 0;
  logic [31:0] exp_misses = 0;

  icache_dm_if cif ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  icache_dm #(.SETS(16)) dut (.CLK(CLK), .RST(RST), .cif(cif),
                              .hit_count(hit_count), .miss_count(miss_count));
`else
  icache_dm #(.SETS(16)) dut (.CLK(CLK), .RST(RST), .cif(cif));
`endif

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ 32'h1357_0000;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_stats(input string name);
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      errors++;
      $display("[TB] FAIL %s: hit_count=%0d miss_count=%0d, required %0d %0d",
               name, hit_count, miss_count, exp_hits, exp_misses);
    end
`else
    if (name.len() == 0) $display("[TB] unnamed stats point");
`endif
  endtask

  // Full miss sequence on a held address: detect, k busy cycles, completion, hit.
  task automatic fetch_miss(input logic [31:0] addr, input int k);
    cif.imemREN = 1'b1; cif.imemaddr = addr; cif.flush = 1'b0;
    cif.iwait = 1'b1; cif.iload = '0;
    #1; checks++;
    if (cif.ihit !== 1'b0 || cif.iREN !== 1'b0) begin
      errors++;
      $display("[TB] FAIL miss_detect %h: ihit=%b iREN=%b, required 0 0", addr, cif.ihit, cif.iREN);
    end
    tick(); exp_misses++;
    for (int c = 0; c <= k; c++) begin
      cif.iwait = (c < k);
      cif.iload = (c < k) ? 32'hDEAD_BEEF : mem_word(addr);
      #1; checks++;
      if (cif.iREN !== 1'b1 || cif.ihit !== 1'b0 || cif.iaddr !== addr) begin
        errors++;
        $display("[TB] FAIL fill_cycle %0d @%h: iREN=%b ihit=%b iaddr=%h, required 1 0 %h",
                 c, addr, cif.iREN, cif.ihit, cif.iaddr, addr);
      end
      tick();
    end
    cif.iwait = 1'b1; cif.iload = '0;
    #1; checks++;
    if (cif.ihit !== 1'b1 || cif.iREN !== 1'b0 || cif.imemload !== mem_word(addr)) begin
      errors++;
      $display("[TB] FAIL fill_hit %h: ihit=%b iREN=%b imemload=%h, required 1 0 %h",
               addr, cif.ihit, cif.iREN, cif.imemload, mem_word(addr));
    end
    tick(); exp_hits++;
  endtask

  task automatic test_reset();
    cif.imemREN = 1'b1; cif.imemaddr = 32'h40; cif.flush = 1'b0;
    cif.iwait = 1'b1; cif.iload = '0;
    RST = 1'b1;
    tick(); tick();
    #1; checks++;
    if (cif.ihit !== 1'b0 || cif.imemload !== 32'h0 || cif.iREN !== 1'b0 || cif.iaddr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ihit=%b imemload=%h iREN=%b iaddr=%h, required all 0",
               cif.ihit, cif.imemload, cif.iREN, cif.iaddr);
    end
    RST = 1'b0;
    #1; checks++;
    if (cif.ihit !== 1'b0 || cif.iREN !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: ihit=%b iREN=%b, required 0 0", cif.ihit, cif.iREN);
    end
    cif.imemREN = 1'b0;
    tick();
    check_stats("reset_counters");
  endtask

  task automatic test_cold_miss();
    fetch_miss(32'h40, 3);
    check_stats("cold_miss_counters");
  endtask

  task automatic test_hit_reuse();
    cif.imemREN = 1'b1; cif.imemaddr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (cif.ihit !== 1'b1 || cif.iREN !== 1'b0 || cif.imemload !== mem_word(32'h40)) begin
        errors++;
        $display("[TB] FAIL hit_reuse %0d: ihit=%b iREN=%b imemload=%h, required 1 0 %h",
                 i, cif.ihit, cif.iREN, cif.imemload, mem_word(32'h40));
      end
      tick(); exp_hits++;
    end
    check_stats("hit_reuse_counters");
  endtask

  task automatic test_conflict();
    fetch_miss(32'h440, 2);
    fetch_miss(32'h40, 1);
    check_stats("conflict_counters");
  endtask

  task automatic test_addr_change_mid_fill();
    cif.imemREN = 1'b1; cif.imemaddr = 32'h80; cif.iwait = 1'b1;
    tick(); exp_misses++;
    cif.imemaddr = 32'h84;
    #1; checks++;
    if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h80 || cif.ihit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midfill_busy: iREN=%b iaddr=%h ihit=%b, required 1 00000080 0",
               cif.iREN, cif.iaddr, cif.ihit);
    end
    tick();
    cif.iwait = 1'b0; cif.iload = mem_word(32'h80);
    #1; checks++;
    if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h80) begin
      errors++;
      $display("[TB] FAIL midfill_done: iREN=%b iaddr=%h, required 1 00000080", cif.iREN, cif.iaddr);
    end
    tick();
    fetch_miss(32'h84, 0);
    cif.imemaddr = 32'h80;
    #1; checks++;
    if (cif.ihit !== 1'b1 || cif.imemload !== mem_word(32'h80)) begin
      errors++;
      $display("[TB] FAIL midfill_frame: ihit=%b imemload=%h, required 1 %h",
               cif.ihit, cif.imemload, mem_word(32'h80));
    end
    tick(); exp_hits++;
    check_stats("midfill_counters");
  endtask

  task automatic test_flush_fill();
    cif.imemREN = 1'b1; cif.imemaddr = 32'h100; cif.iwait = 1'b1;
    tick(); exp_misses++;
    cif.flush = 1'b1; cif.iwait = 1'b0; cif.iload = mem_word(32'h100);
    #1; checks++;
    if (cif.iREN !== 1'b1 || cif.ihit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_fill_cycle: iREN=%b ihit=%b, required 1 0", cif.iREN, cif.ihit);
    end
    tick();
    cif.flush = 1'b0; cif.iwait = 1'b1; cif.iload = '0;
    for (int i = 0; i < 2; i++) begin
      cif.imemaddr = (i == 0) ? 32'h84 : 32'h100;
      #1; checks++;
      if (cif.ihit !== 1'b0 || cif.iREN !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_invalid %h: ihit=%b iREN=%b, required 0 0",
                 cif.imemaddr, cif.ihit, cif.iREN);
      end
    end
    fetch_miss(32'h100, 1);
    cif.flush = 1'b1;
    #1; checks++;
    if (cif.ihit !== 1'b0 || cif.imemload !== 32'h0) begin
      errors++;
      $display("[TB] FAIL flush_idle_force: ihit=%b imemload=%h, required 0 0", cif.ihit, cif.imemload);
    end
    tick();
    cif.flush = 1'b0;
    #1; checks++;
    if (cif.ihit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle_cleared: ihit=%b, required 0", cif.ihit);
    end
    tick(); exp_misses++;
    check_stats("flush_counters");
  endtask

  task automatic test_reset_mid_fill();
    #1; checks++;
    if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h100) begin
      errors++;
      $display("[TB] FAIL pre_reset_fill: iREN=%b iaddr=%h, required 1 00000100", cif.iREN, cif.iaddr);
    end
    RST = 1'b1;
    #1; checks++;
    if (cif.iREN !== 1'b0 || cif.iaddr !== 32'h0 || cif.ihit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_fill: iREN=%b iaddr=%h ihit=%b, required 0 0 0",
               cif.iREN, cif.iaddr, cif.ihit);
    end
    tick();
    RST = 1'b0; exp_hits = 0; exp_misses = 0;
    #1; checks++;
    if (cif.iREN !== 1'b0 || cif.ihit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset_fill: iREN=%b ihit=%b, required 0 0", cif.iREN, cif.ihit);
    end
    check_stats("reset_fill_counters");
    fetch_miss(32'h40, 0);
    check_stats("final_counters");
    cif.imemREN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_reuse();
    test_conflict();
    test_addr_change_mid_fill();
    test_flush_fill();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
